// File: rtl/bk_pkg.sv
// Shared types and constants for the BK-0010 keyboard/scroll register group.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bk_pkg;

    // Bus cycle states of the Qbus slave sequencer
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_IAK  = 3'd5
    } bk_state_t;

    // Word offsets inside the 4-word window (addr[2:1])
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_SCROLL = 2'd2;

    // Default placement and reset values
    localparam logic [15:0] BK_BASE_DEF       = 16'o177660;
    localparam logic [15:0] BK_VECTOR_DEF     = 16'o000060;
    localparam logic [15:0] BK_SCROLL_RST_DEF = 16'o001330;

    // Scroll register implements bit 9 and bits 7:0 only
    localparam logic [15:0] SCROLL_MASK = 16'o001377;

    // Status register bit positions
    localparam int STATUS_READY_BIT = 7;
    localparam int STATUS_IE_BIT    = 6;

    // Assemble the status word; every unlisted bit reads as zero
    function automatic logic [15:0] status_word(input logic ready, input logic ie);
        logic [15:0] w;
        w = 16'h0000;
        w[STATUS_READY_BIT] = ready;
        w[STATUS_IE_BIT]    = ie;
        return w;
    endfunction

endpackage

// File: rtl/bk_qbus_slave_fsm.sv
// Qbus slave sequencer: address latch/decode, DIN/DOUT/IAK strobe handling, RPLY and AD enables.
// Latency: RPLY and read data appear on the edge that samples the strobe low; released on the edge sampling it high.
// Backpressure: the master holds its strobe until RPLY; unselected cycles are never answered.
module bk_qbus_slave_fsm
    import bk_pkg::*;
#(
    parameter logic [15:0] BASE   = BK_BASE_DEF,
    parameter logic [15:0] VECTOR = BK_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_n,
    input  logic        sync_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic        iako_n,
    input  logic [15:0] ad_in,
    input  logic [15:0] rdata,
    input  logic        irq_req,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic [1:0]  wr_mask,
    output logic [1:0]  reg_sel,
    output logic        iak_stb,
    output logic        rply_oe,
    output logic        ad_oe,
    output logic [15:0] ad_dat
);

    bk_state_t   state;
    logic [15:0] addr;
    logic        byte_wr;
    logic        sel;
    logic        addr_hit;

    // Offset +6 lies inside the aligned window but is deliberately left undecoded
    assign addr_hit = (ad_in[15:3] == BASE[15:3]) && (ad_in[2:1] != 2'b11);

    assign reg_sel = addr[2:1];
    assign wr_mask = byte_wr ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;

    // Register-side strobes fire on the same edge the FSM commits the transfer; DIN wins over DOUT
    assign rd_stb  = init_n && (state == ST_ADDR) && !sync_n && !din_n && sel;
    assign wr_stb  = init_n && (state == ST_ADDR) && !sync_n && din_n && !dout_n && sel;
    assign iak_stb = init_n && (state == ST_IDLE) && sync_n && !din_n && !iako_n && irq_req;

    // Bus cycle sequencer with registered RPLY/AD enables and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr    <= 16'h0000;
            byte_wr <= 1'b0;
            sel     <= 1'b0;
            rply_oe <= 1'b0;
            ad_oe   <= 1'b0;
            ad_dat  <= 16'h0000;
        end else if (!init_n) begin
            state   <= ST_IDLE;
            addr    <= 16'h0000;
            byte_wr <= 1'b0;
            sel     <= 1'b0;
            rply_oe <= 1'b0;
            ad_oe   <= 1'b0;
            ad_dat  <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!sync_n) begin
                        state   <= ST_ADDR;
                        addr    <= ad_in;
                        byte_wr <= !wtbt_n;
                        sel     <= addr_hit;
                    end else if (iak_stb) begin
                        state   <= ST_IAK;
                        ad_dat  <= VECTOR;
                        ad_oe   <= 1'b1;
                        rply_oe <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sync_n) begin
                        state <= ST_IDLE;
                    end else if (rd_stb) begin
                        state   <= ST_RD;
                        ad_dat  <= rdata;
                        ad_oe   <= 1'b1;
                        rply_oe <= 1'b1;
                    end else if (wr_stb) begin
                        state   <= ST_WR;
                        rply_oe <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (sync_n) begin
                        state   <= ST_IDLE;
                        ad_oe   <= 1'b0;
                        rply_oe <= 1'b0;
                    end else if (din_n) begin
                        state   <= ST_DONE;
                        ad_oe   <= 1'b0;
                        rply_oe <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (sync_n) begin
                        state   <= ST_IDLE;
                        rply_oe <= 1'b0;
                    end else if (dout_n) begin
                        state   <= ST_DONE;
                        rply_oe <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (sync_n) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IAK: begin
                    if (din_n) begin
                        state   <= ST_IDLE;
                        ad_oe   <= 1'b0;
                        rply_oe <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ad_oe   <= 1'b0;
                    rply_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bk_kbd_slave.sv
// BK-0010 keyboard/scroll register slave (177660..177664) with optional vectored IRQ (BK_KBD_IRQ_EN).
// Latency: RPLY one cycle after DIN/DOUT is sampled low; released one cycle after the strobe rises.
// Backpressure: none internally; keyboard strobes always land, overwriting an unread code.
module bk_kbd_slave
    import bk_pkg::*;
#(
    parameter logic [15:0] BASE       = BK_BASE_DEF,
    parameter logic [15:0] VECTOR     = BK_VECTOR_DEF,
    parameter logic [15:0] SCROLL_RST = BK_SCROLL_RST_DEF
) (
    input  logic       pin_clk,
    input  logic       pin_dclo_n,
    input  logic       pin_init_n,
    inout  wire [15:0] pin_ad_n,
    input  logic       pin_sync_n,
    input  logic       pin_din_n,
    input  logic       pin_dout_n,
    input  logic       pin_wtbt_n,
    inout  wire        pin_rply_n,
    input  logic       pin_iako_n,
    output wire        pin_virq_n,
    input  logic       kbd_stb,
    input  logic [6:0] kbd_code
);

    logic        rd_stb;
    logic        wr_stb;
    logic [1:0]  wr_mask;
    logic [1:0]  reg_sel;
    logic        iak_stb;
    logic        rply_oe;
    logic        ad_oe;
    logic [15:0] ad_dat;
    logic [15:0] wdat;
    logic [15:0] rdata;
    logic [15:0] wr_lanes;
    logic        irq_req;
    logic        ie;
    logic        ready;
    logic [6:0]  kbd_data;
    logic [15:0] scroll;

    // The bus is inverted; everything inside works on true data
    assign wdat       = ~pin_ad_n;
    assign pin_ad_n   = ad_oe ? ~ad_dat : 16'bz;
    assign pin_rply_n = rply_oe ? 1'b0 : 1'bz;

    assign wr_lanes = {{8{wr_mask[1]}}, {8{wr_mask[0]}}};

    bk_qbus_slave_fsm #(
        .BASE   (BASE),
        .VECTOR (VECTOR)
    ) u_fsm (
        .clk     (pin_clk),
        .rst_n   (pin_dclo_n),
        .init_n  (pin_init_n),
        .sync_n  (pin_sync_n),
        .din_n   (pin_din_n),
        .dout_n  (pin_dout_n),
        .wtbt_n  (pin_wtbt_n),
        .iako_n  (pin_iako_n),
        .ad_in   (wdat),
        .rdata   (rdata),
        .irq_req (irq_req),
        .rd_stb  (rd_stb),
        .wr_stb  (wr_stb),
        .wr_mask (wr_mask),
        .reg_sel (reg_sel),
        .iak_stb (iak_stb),
        .rply_oe (rply_oe),
        .ad_oe   (ad_oe),
        .ad_dat  (ad_dat)
    );

    // Read mux for the selected word; unimplemented bits read as zero
    always_comb begin
        rdata = 16'h0000;
        case (reg_sel)
            REG_STATUS: rdata = status_word(ready, ie);
            REG_DATA:   rdata = {9'b0, kbd_data};
            REG_SCROLL: rdata = scroll & SCROLL_MASK;
            default:    rdata = 16'h0000;
        endcase
    end

    // Keyboard latch and scroll register; a new key beats a same-cycle data read
    always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            ready    <= 1'b0;
            kbd_data <= 7'd0;
            scroll   <= SCROLL_RST;
        end else if (!pin_init_n) begin
            ready    <= 1'b0;
            kbd_data <= 7'd0;
            scroll   <= SCROLL_RST;
        end else begin
            if (kbd_stb) begin
                kbd_data <= kbd_code;
                ready    <= 1'b1;
            end else if (rd_stb && (reg_sel == REG_DATA)) begin
                ready <= 1'b0;
            end
            if (wr_stb && (reg_sel == REG_SCROLL)) begin
                scroll <= (scroll & ~(wr_lanes & SCROLL_MASK)) | (wdat & wr_lanes & SCROLL_MASK);
            end
        end
    end

`ifdef BK_KBD_IRQ_EN
    logic pend;

    // Interrupt enable and pending flag; clearing IE masks the request but keeps it pending
    always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            ie   <= 1'b0;
            pend <= 1'b0;
        end else if (!pin_init_n) begin
            ie   <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (wr_stb && (reg_sel == REG_STATUS) && wr_mask[0]) begin
                ie <= wdat[STATUS_IE_BIT];
            end
            if (kbd_stb) begin
                pend <= ie;
            end else if (iak_stb) begin
                pend <= 1'b0;
            end
        end
    end

    assign irq_req    = pend & ie;
    assign pin_virq_n = irq_req ? 1'b0 : 1'bz;
`else
    logic unused_iak;

    assign ie         = 1'b0;
    assign irq_req    = 1'b0;
    assign pin_virq_n = 1'bz;
    assign unused_iak = iak_stb;
`endif

endmodule

// File: tb/tb_bk_kbd_slave.sv
// Directed bench for bk_kbd_slave: register reads/writes, keyboard path, IRQ/IAK (BK_KBD_IRQ_EN), decode, resets.
// Latency: expects RPLY on the first edge after a strobe is sampled low.
// Backpressure: every wait for RPLY is bounded to a few cycles.
module tb_bk_kbd_slave;
    import bk_pkg::*;

`ifdef BK_KBD_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        pin_clk;
    logic        pin_dclo_n;
    logic        pin_init_n;
    logic        pin_sync_n;
    logic        pin_din_n;
    logic        pin_dout_n;
    logic        pin_wtbt_n;
    logic        pin_iako_n;
    logic        kbd_stb;
    logic [6:0]  kbd_code;
    logic [15:0] tb_ad;
    logic        tb_ad_oe;
    wire  [15:0] ad_n;
    wire         rply_n;
    wire         virq_n;

    int n_chk  = 0;
    int n_pass = 0;

    assign ad_n = tb_ad_oe ? tb_ad : 16'bz;
    pullup (rply_n);
    pullup (virq_n);

    bk_kbd_slave dut (
        .pin_clk    (pin_clk),
        .pin_dclo_n (pin_dclo_n),
        .pin_init_n (pin_init_n),
        .pin_ad_n   (ad_n),
        .pin_sync_n (pin_sync_n),
        .pin_din_n  (pin_din_n),
        .pin_dout_n (pin_dout_n),
        .pin_wtbt_n (pin_wtbt_n),
        .pin_rply_n (rply_n),
        .pin_iako_n (pin_iako_n),
        .pin_virq_n (virq_n),
        .kbd_stb    (kbd_stb),
        .kbd_code   (kbd_code)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %06o expected %06o", tag, got, exp);
    endtask

    task automatic bus_read(input logic [15:0] a, input bit kstb, input logic [6:0] kc,
                            output logic [15:0] d, output bit rp, output int lat,
                            output bit drove, output bit rel);
        d = 16'hffff; rp = 1'b0; lat = 0; drove = 1'b0; rel = 1'b0;
        @(negedge pin_clk);
        tb_ad = ~a; tb_ad_oe = 1'b1; pin_wtbt_n = 1'b1; pin_sync_n = 1'b0;
        @(negedge pin_clk);
        tb_ad_oe = 1'b0; pin_din_n = 1'b0;
        if (kstb) begin
            kbd_stb = 1'b1; kbd_code = kc;
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge pin_clk); #1;
            kbd_stb = 1'b0;
            lat++;
            drove = drove | dut.u_fsm.ad_oe;
            if (!rply_n) begin
                rp = 1'b1; d = ~ad_n;
                break;
            end
        end
        @(negedge pin_clk); pin_din_n = 1'b1;
        @(posedge pin_clk); #1; rel = rply_n;
        @(negedge pin_clk); pin_sync_n = 1'b1;
        @(negedge pin_clk);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d; bit rp; int lat; bit drove; bit rel;
        bus_read(a, 1'b0, 7'd0, d, rp, lat, drove, rel);
        chk({tag, "_rply"}, 16'(rp), 16'd1);
        chk(tag, d, exp);
    endtask

    task automatic bus_write(input logic [15:0] a, input bit byte_wr, input logic [15:0] v,
                             output bit rp, output bit rel);
        rp = 1'b0; rel = 1'b0;
        @(negedge pin_clk);
        tb_ad = ~a; tb_ad_oe = 1'b1; pin_wtbt_n = ~byte_wr; pin_sync_n = 1'b0;
        @(negedge pin_clk);
        tb_ad = ~v; pin_wtbt_n = 1'b1; pin_dout_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pin_clk); #1;
            if (!rply_n) begin
                rp = 1'b1;
                break;
            end
        end
        @(negedge pin_clk); pin_dout_n = 1'b1;
        @(posedge pin_clk); #1; rel = rply_n;
        @(negedge pin_clk); pin_sync_n = 1'b1; tb_ad_oe = 1'b0;
        @(negedge pin_clk);
    endtask

    task automatic wr_chk(input string tag, input logic [15:0] a, input bit byte_wr, input logic [15:0] v);
        bit rp; bit rel;
        bus_write(a, byte_wr, v, rp, rel);
        chk({tag, "_rply"}, 16'(rp), 16'd1);
    endtask

    task automatic bus_iak(output logic [15:0] d, output bit rp, output bit rel);
        d = 16'hffff; rp = 1'b0; rel = 1'b0;
        @(negedge pin_clk);
        pin_iako_n = 1'b0; pin_din_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pin_clk); #1;
            if (!rply_n) begin
                rp = 1'b1; d = ~ad_n;
                break;
            end
        end
        @(negedge pin_clk); pin_din_n = 1'b1; pin_iako_n = 1'b1;
        @(posedge pin_clk); #1; rel = rply_n;
        @(negedge pin_clk);
    endtask

    task automatic kbd_key(input logic [6:0] kc);
        @(negedge pin_clk); kbd_stb = 1'b1; kbd_code = kc;
        @(negedge pin_clk); kbd_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        bit rp; bit rel; bit drove; int lat;

        pin_dclo_n = 1'b0; pin_init_n = 1'b1;
        pin_sync_n = 1'b1; pin_din_n = 1'b1; pin_dout_n = 1'b1;
        pin_wtbt_n = 1'b1; pin_iako_n = 1'b1;
        kbd_stb = 1'b0; kbd_code = 7'd0; tb_ad = 16'hffff; tb_ad_oe = 1'b0;
        repeat (3) @(negedge pin_clk);

        // Reset state
        chk("rst_rply", 16'(rply_n), 16'd1);
        chk("rst_virq", 16'(virq_n), 16'd1);
        chk("rst_ad_oe", 16'(dut.u_fsm.ad_oe), 16'd0);
        chk("rst_state", 16'(dut.u_fsm.state), 16'(ST_IDLE));
        pin_dclo_n = 1'b1;
        repeat (2) @(negedge pin_clk);

        // Scroll reset value, reply latency and release
        bus_read(16'o177664, 1'b0, 7'd0, d, rp, lat, drove, rel);
        chk("scroll_rst", d, 16'o001330);
        chk("rd_latency", 16'(lat), 16'd1);
        chk("rd_release", 16'(rel), 16'd1);
        rd_chk("status_rst", 16'o177660, 16'o000000);

        // Keyboard path
        kbd_key(7'o101);
        rd_chk("status_ready", 16'o177660, 16'o000200);
        rd_chk("data_101", 16'o177662, 16'o000101);
        rd_chk("status_clr", 16'o177660, 16'o000000);

        // Scroll byte/word writes
        bus_write(16'o177665, 1'b1, 16'o125000, rp, rel);
        chk("bwr_hi_rply", 16'(rp), 16'd1);
        chk("wr_release", 16'(rel), 16'd1);
        rd_chk("scroll_bhi_aa", 16'o177664, 16'o001330);
        wr_chk("bwr_hi0", 16'o177665, 1'b1, 16'o000000);
        rd_chk("scroll_bhi_0", 16'o177664, 16'o000330);
        wr_chk("wwr_all", 16'o177664, 1'b0, 16'o177777);
        rd_chk("scroll_word", 16'o177664, 16'o001377);
        wr_chk("bwr_lo0", 16'o177664, 1'b1, 16'o000000);
        rd_chk("scroll_blo_0", 16'o177664, 16'o001000);

        // Data register ignores writes
        wr_chk("data_wr", 16'o177662, 1'b0, 16'o000000);
        rd_chk("data_ro", 16'o177662, 16'o000101);

        // Strobe coinciding with a data read: old code returned, new key stays ready
        bus_read(16'o177662, 1'b1, 7'o055, d, rp, lat, drove, rel);
        chk("race_old_data", d, 16'o000101);
        rd_chk("race_ready", 16'o177660, 16'o000200);
        rd_chk("race_new_data", 16'o177662, 16'o000055);

        // Overwrite of an unread code
        kbd_key(7'o001);
        kbd_key(7'o002);
        rd_chk("overwrite", 16'o177662, 16'o000002);

        // Interrupt path
        wr_chk("ie_set", 16'o177660, 1'b0, 16'o000100);
        rd_chk("status_ie", 16'o177660, HAS_IRQ ? 16'o000100 : 16'o000000);
        chk("virq_idle", 16'(virq_n), 16'd1);
        kbd_key(7'o012);
        chk("virq_req", 16'(virq_n), HAS_IRQ ? 16'd0 : 16'd1);
        rd_chk("status_ie_rdy", 16'o177660, HAS_IRQ ? 16'o000300 : 16'o000200);
        bus_iak(d, rp, rel);
        chk("iak_rply", 16'(rp), HAS_IRQ ? 16'd1 : 16'd0);
        chk("iak_vector", d, HAS_IRQ ? 16'o000060 : 16'hffff);
        chk("iak_release", 16'(rel), 16'd1);
        chk("virq_after_iak", 16'(virq_n), 16'd1);
        kbd_key(7'o013);
        chk("virq_req2", 16'(virq_n), HAS_IRQ ? 16'd0 : 16'd1);
        wr_chk("ie_clr", 16'o177660, 1'b0, 16'o000000);
        chk("virq_masked", 16'(virq_n), 16'd1);
        wr_chk("ie_reset", 16'o177660, 1'b0, 16'o000100);
        chk("virq_pend_kept", 16'(virq_n), HAS_IRQ ? 16'd0 : 16'd1);
        bus_iak(d, rp, rel);
        chk("iak2_rply", 16'(rp), HAS_IRQ ? 16'd1 : 16'd0);
        chk("virq_after_iak2", 16'(virq_n), 16'd1);

        // Undecoded addresses
        bus_read(16'o177666, 1'b0, 7'd0, d, rp, lat, drove, rel);
        chk("off6_rply", 16'(rp), 16'd0);
        chk("off6_drive", 16'(drove), 16'd0);
        chk("off6_idle", 16'(dut.u_fsm.state), 16'(ST_IDLE));
        bus_read(16'o177700, 1'b0, 7'd0, d, rp, lat, drove, rel);
        chk("far_rply", 16'(rp), 16'd0);
        chk("far_drive", 16'(drove), 16'd0);
        chk("far_idle", 16'(dut.u_fsm.state), 16'(ST_IDLE));

        // Bus INIT
        @(negedge pin_clk); pin_init_n = 1'b0;
        @(negedge pin_clk); pin_init_n = 1'b1;
        rd_chk("init_status", 16'o177660, 16'o000000);
        rd_chk("init_scroll", 16'o177664, 16'o001330);
        rd_chk("init_data", 16'o177662, 16'o000000);

        // DCLO in the middle of a read
        kbd_key(7'o033);
        wr_chk("scroll_zero", 16'o177664, 1'b0, 16'o000000);
        @(negedge pin_clk);
        tb_ad = ~16'o177662; tb_ad_oe = 1'b1; pin_wtbt_n = 1'b1; pin_sync_n = 1'b0;
        @(negedge pin_clk);
        tb_ad_oe = 1'b0; pin_din_n = 1'b0;
        @(posedge pin_clk); #1;
        chk("dclo_pre_rply", 16'(rply_n), 16'd0);
        chk("dclo_pre_data", ~ad_n, 16'o000033);
        #2 pin_dclo_n = 1'b0;
        #1;
        chk("dclo_rply_rel", 16'(rply_n), 16'd1);
        chk("dclo_ad_rel", 16'(dut.u_fsm.ad_oe), 16'd0);
        @(negedge pin_clk); pin_din_n = 1'b1; pin_sync_n = 1'b1;
        @(negedge pin_clk); pin_dclo_n = 1'b1;
        @(negedge pin_clk);
        rd_chk("dclo_data", 16'o177662, 16'o000000);
        rd_chk("dclo_status", 16'o177660, 16'o000000);
        rd_chk("dclo_scroll", 16'o177664, 16'o001330);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
